// File: rtl/led_seq_pkg.sv
// Shared types and helpers for the LED step sequencer.
// Mode codes, FSM states and the step counter width.
package led_seq_pkg;

  localparam logic [1:0] MODE_FILL   = 2'd0;
  localparam logic [1:0] MODE_CHASE  = 2'd1;
  localparam logic [1:0] MODE_CNTDN  = 2'd2;
  localparam logic [1:0] MODE_BOUNCE = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  // Step counter width: max(1, clog2(n)).
  function automatic int step_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pb_sync_edge.sv
// Push-button synchroniser with falling-edge detector.
// Emits a registered one-cycle press pulse per button press.
module pb_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic o_clk,
  input  logic rst,
  input  logic pb_n,
  output logic press
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_last;
  logic                   r_press;

  // Shift pb_n through the chain and flag the 1->0 transition.
  always_ff @(posedge o_clk or posedge rst) begin
    if (rst) begin
      r_sync  <= '1;
      r_last  <= 1'b1;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], pb_n};
      r_last  <= r_sync[SYNC_STAGES-1];
      r_press <= r_last & ~r_sync[SYNC_STAGES-1];
    end
  end

  assign press = r_press;

endmodule

// File: rtl/led_step_sequencer.sv
// N-LED step sequencer with four patterns and pause/resume.
// A button press starts, pauses, resumes or restarts a run.
module led_step_sequencer
  import led_seq_pkg::*;
#(
  parameter int N_LED       = 4,
  parameter int DIP_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             o_clk,
  input  logic             rst,
  input  logic [DIP_W-1:0] dip,
  input  logic [1:0]       mode,
  input  logic             pb_n,
  output logic [N_LED-1:0] led_n,
  output logic             busy,
  output logic             done
);

  localparam int SW = step_width(N_LED);
  localparam logic [SW-1:0] LAST = SW'(N_LED - 1);

  state_t           r_state;
  state_t           w_next;
  logic [DIP_W-1:0] r_per;
  logic [DIP_W-1:0] r_tick;
  logic [1:0]       r_mode;
  logic [SW-1:0]    r_step;
  logic             r_dir;
  logic             r_busy;
  logic             r_done;
  logic             w_press;
  logic             w_tick_end;
  logic             w_last;
  logic             w_start;
  logic             w_adv;
  logic [N_LED-1:0] w_lit;

  pb_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_pb (
    .o_clk(o_clk),
    .rst  (rst),
    .pb_n (pb_n),
    .press(w_press)
  );

  assign w_tick_end = (r_tick == r_per - DIP_W'(1));
  assign w_last     = (r_step == LAST);
  assign w_start    = w_press &&
                      (r_state == IDLE || r_state == DONE);
  assign w_adv      = (r_state == RUN) && !w_press;

  // Next-state decode; a press always wins over a step boundary.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (w_press) w_next = RUN;
      RUN: begin
        if (w_press)
          w_next = PAUSE;
        else if (w_tick_end && w_last &&
                 r_mode != MODE_BOUNCE)
          w_next = DONE;
      end
      PAUSE: if (w_press) w_next = RUN;
      DONE:  if (w_press) w_next = RUN;
      default: w_next = IDLE;
    endcase
  end

  // State register with busy/done registered alongside.
  always_ff @(posedge o_clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == RUN) || (w_next == PAUSE);
      r_done  <= (w_next == DONE);
    end
  end

  // Latch period/mode on start; advance tick, step and bounce direction.
  always_ff @(posedge o_clk or posedge rst) begin
    if (rst) begin
      r_per  <= DIP_W'(1);
      r_mode <= MODE_FILL;
      r_tick <= '0;
      r_step <= '0;
      r_dir  <= 1'b1;
    end else if (w_start) begin
      r_per  <= (dip == '0) ? DIP_W'(1) : dip;
      r_mode <= mode;
      r_tick <= '0;
      r_step <= '0;
      r_dir  <= 1'b1;
    end else if (w_adv && w_tick_end) begin
      r_tick <= '0;
      if (r_mode != MODE_BOUNCE) begin
        if (!w_last)
          r_step <= r_step + SW'(1);
      end else if (r_dir) begin
        if (w_last) begin
          r_dir  <= 1'b0;
          r_step <= r_step - SW'(1);
        end else begin
          r_step <= r_step + SW'(1);
        end
      end else begin
        if (r_step == '0) begin
          r_dir  <= 1'b1;
          r_step <= r_step + SW'(1);
        end else begin
          r_step <= r_step - SW'(1);
        end
      end
    end else if (w_adv) begin
      r_tick <= r_tick + DIP_W'(1);
    end
  end

  // Pattern decode from registered state, step and mode only.
  always_comb begin
    w_lit = '0;
    if (r_state != IDLE) begin
      for (int i = 0; i < N_LED; i++) begin
        unique case (r_mode)
          MODE_FILL:  w_lit[i] = (i <= int'(r_step));
          MODE_CHASE: w_lit[i] = (i == int'(r_step));
          MODE_CNTDN: w_lit[i] = (i <= N_LED - 1 - int'(r_step));
          default:    w_lit[i] = (i == int'(r_step));
        endcase
      end
    end
  end

  assign led_n = ~w_lit;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_led_step_sequencer.sv
// Self-checking bench for led_step_sequencer.
// Cycle-level model plus hand-computed literal checkpoints.
module tb_led_step_sequencer;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int S  = 2;

  logic          o_clk = 1'b0;
  logic          rst   = 1'b1;
  logic          pb_n  = 1'b1;
  logic [DW-1:0] dip   = 4'd3;
  logic [1:0]    mode  = 2'd0;
  logic [N-1:0]  led_n;
  logic          busy;
  logic          done;

  led_step_sequencer #(
    .N_LED(N),
    .DIP_W(DW),
    .SYNC_STAGES(S)
  ) dut (
    .o_clk(o_clk),
    .rst  (rst),
    .dip  (dip),
    .mode (mode),
    .pb_n (pb_n),
    .led_n(led_n),
    .busy (busy),
    .done (done)
  );

  always #5 o_clk = ~o_clk;

  int checks   = 0;
  int failures = 0;

  // Model: state 0 idle, 1 run, 2 pause, 3 done; k = run cycles elapsed.
  int         m_st   = 0;
  int         m_k    = 0;
  int         m_p    = 1;
  int         m_mode = 0;
  logic [S+1:0] hist = '1;
  logic       m_pr;

  always @(posedge o_clk or posedge rst) begin
    if (rst) begin
      m_st = 0;
      m_k  = 0;
      hist = '1;
    end else begin
      m_pr = hist[S+1] & ~hist[S];
      hist = {hist[S:0], pb_n};
      case (m_st)
        0, 3: if (m_pr) begin
          m_st   = 1;
          m_k    = 0;
          m_p    = (dip == 0) ? 1 : int'(dip);
          m_mode = int'(mode);
        end
        1: begin
          if (m_pr) m_st = 2;
          else if (m_mode != 3 && m_k == N * m_p - 1) m_st = 3;
          else m_k++;
        end
        2: if (m_pr) m_st = 1;
        default: m_st = 0;
      endcase
    end
  end

  function automatic logic [N-1:0] exp_led(int st, int k, int p, int md);
    logic [N-1:0] lit;
    int stp;
    int pos;
    int c;
    lit = '0;
    if (st == 0) return '1;
    stp = k / p;
    c   = 2 * N - 2;
    pos = stp % c;
    if (pos >= N) pos = c - pos;
    for (int i = 0; i < N; i++) begin
      case (md)
        0:       lit[i] = (i <= stp);
        1:       lit[i] = (i == stp);
        2:       lit[i] = (i <= N - 1 - stp);
        default: lit[i] = (i == pos);
      endcase
    end
    return ~lit;
  endfunction

  int           lit_seq = 0;
  int           lit_ack = 0;
  string        lit_name = "";
  logic [N-1:0] lit_led;
  logic         lit_busy;
  logic         lit_done;
  logic [N-1:0] e_led;
  logic         e_busy;
  logic         e_done;

  // Compare DUT against model every cycle, plus pending literal checks.
  always @(negedge o_clk) begin
    e_led  = exp_led(m_st, m_k, m_p, m_mode);
    e_busy = (m_st == 1) || (m_st == 2);
    e_done = (m_st == 3);
    checks++;
    if ({led_n, busy, done} !== {e_led, e_busy, e_done}) begin
      failures++;
      $display("FAIL model t=%0t led_n=%b busy=%b done=%b want led_n=%b busy=%b done=%b",
               $time, led_n, busy, done, e_led, e_busy, e_done);
    end
    if (lit_seq != lit_ack) begin
      lit_ack = lit_seq;
      checks++;
      if ({led_n, busy, done} !== {lit_led, lit_busy, lit_done}) begin
        failures++;
        $display("FAIL %s t=%0t led_n=%b busy=%b done=%b want led_n=%b busy=%b done=%b",
                 lit_name, $time, led_n, busy, done,
                 lit_led, lit_busy, lit_done);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge o_clk);
    #1;
  endtask

  task automatic lit(input string nm, input logic [N-1:0] l,
                     input logic b, input logic d);
    lit_name = nm;
    lit_led  = l;
    lit_busy = b;
    lit_done = d;
    lit_seq++;
    @(negedge o_clk);
    #1;
  endtask

  task automatic press_for(input int n);
    pb_n = 1'b0;
    cyc(n);
    pb_n = 1'b1;
  endtask

  initial begin
    cyc(3);
    rst = 1'b0;
    cyc(2);
    lit("idle_after_reset", 4'b1111, 0, 0);

    // FILL, P=3
    dip = 4'd3; mode = 2'd0;
    pb_n = 1'b0;
    cyc(3);
    pb_n = 1'b1;
    lit("fill_not_yet", 4'b1111, 0, 0);
    cyc(1); lit("fill_s0", 4'b1110, 1, 0);
    cyc(3); lit("fill_s1", 4'b1100, 1, 0);
    cyc(3); lit("fill_s2", 4'b1000, 1, 0);
    cyc(3); lit("fill_s3", 4'b0000, 1, 0);
    cyc(3); lit("fill_done", 4'b0000, 0, 1);
    cyc(5); lit("fill_hold", 4'b0000, 0, 1);

    // CHASE, dip=0 means P=1; dip change mid-run ignored
    dip = 4'd0; mode = 2'd1;
    press_for(2);
    cyc(2); lit("chase_s0", 4'b1110, 1, 0);
    dip = 4'd5;
    cyc(1); lit("chase_s1", 4'b1101, 1, 0);
    cyc(1); lit("chase_s2", 4'b1011, 1, 0);
    cyc(1); lit("chase_s3", 4'b0111, 1, 0);
    cyc(1); lit("chase_done", 4'b0111, 0, 1);

    // COUNTDOWN, P=4, pause at step 1 tick 2
    dip = 4'd4; mode = 2'd2;
    press_for(2);
    cyc(2); lit("cd_s0", 4'b0000, 1, 0);
    cyc(3);
    press_for(2);
    cyc(2);  lit("cd_pause", 4'b1000, 1, 0);
    cyc(19); lit("cd_frozen", 4'b1000, 1, 0);
    press_for(2);
    cyc(2); lit("cd_resume", 4'b1000, 1, 0);
    cyc(1); lit("cd_tick3", 4'b1000, 1, 0);
    cyc(1); lit("cd_s2", 4'b1100, 1, 0);
    cyc(7); lit("cd_s3", 4'b1110, 1, 0);
    cyc(1); lit("cd_done", 4'b1110, 0, 1);

    // BOUNCE, P=2
    dip = 4'd2; mode = 2'd3;
    press_for(2);
    cyc(2); lit("b_p0", 4'b1110, 1, 0);
    cyc(2); lit("b_p1", 4'b1101, 1, 0);
    cyc(2); lit("b_p2", 4'b1011, 1, 0);
    cyc(2); lit("b_p3", 4'b0111, 1, 0);
    cyc(2); lit("b_p2b", 4'b1011, 1, 0);
    cyc(2); lit("b_p1b", 4'b1101, 1, 0);
    cyc(2); lit("b_p0b", 4'b1110, 1, 0);
    cyc(2); lit("b_p1c", 4'b1101, 1, 0);
    cyc(2); lit("b_p2c", 4'b1011, 1, 0);
    cyc(100); lit("b_long", 4'b1011, 1, 0);

    // Async reset in the middle of a FILL run at step 2
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(2);
    dip = 4'd3; mode = 2'd0;
    press_for(2);
    cyc(8); lit("rst_pre_s2", 4'b1000, 1, 0);
    cyc(1);
    rst = 1'b1;
    lit("rst_async", 4'b1111, 0, 0);
    cyc(2);
    rst = 1'b0;
    cyc(10); lit("rst_idle", 4'b1111, 0, 0);

    // Button held for 50 cycles: one start, no pause
    dip = 4'd3; mode = 2'd0;
    pb_n = 1'b0;
    cyc(4);  lit("hold_start", 4'b1110, 1, 0);
    cyc(16); lit("hold_done", 4'b0000, 0, 1);
    cyc(30);
    pb_n = 1'b1;
    cyc(5);  lit("hold_release", 4'b0000, 0, 1);
    press_for(2);
    cyc(2); lit("restart_s0", 4'b1110, 1, 0);
    cyc(3); lit("restart_s1", 4'b1100, 1, 0);
    cyc(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_step_sequencer.md
Name: led_step_sequencer

Overview:
Parametrised LED step sequencer clocked by the divided clock o_clk. A debounced, synchronised active-low push-button starts, pauses and resumes a run. The LEDs then advance one step every P ticks, where P is taken from the DIP switches, using one of four patterns. It generalises the fixed 4-LED, fixed-pattern sequencer to N LEDs, selectable modes, pause/resume and a completion flag.

Parameters:
N_LED, 4, number of LEDs driven (min 2)
DIP_W, 4, width of the period input dip
SYNC_STAGES, 2, flip-flop stages synchronising pb_n (min 2)

Ports:
o_clk  in  1  divided system clock; all logic on its rising edge
rst  in  1  asynchronous, active-high reset
dip  in  DIP_W  step period P in o_clk ticks; 0 is treated as 1
mode  in  2  pattern: 0 FILL, 1 CHASE, 2 COUNTDOWN, 3 BOUNCE
pb_n  in  1  push-button, active-low, asynchronous to o_clk
led_n  out  N_LED  LED drive, active-low (1 = off)
busy  out  1  high in RUN or PAUSE
done  out  1  high in DONE

Behaviour:
- Reset (asynchronous, any state, takes effect immediately): state=IDLE, led_n all 1, busy=0, done=0, step=0, tick=0, sync chain=1.
- Press detection: pb_n passes through SYNC_STAGES flops. A press is the 1->0 transition of the synchronised signal and lasts a single cycle. The press pulse is valid SYNC_STAGES+1 cycles after pb_n falls. Holding the button produces only one press.
- Latching: on every IDLE->RUN or DONE->RUN transition, latch P = max(dip,1) and mode. Changes to dip or mode mid-run are ignored.
- Counters: tick width DIP_W, step width max(1,clog2(N_LED)). In RUN, tick counts from 0 to P-1. When tick=P-1, tick resets to 0 and step advances.
- States:
  - IDLE: led_n all 1. A press goes to RUN with step=0 and tick=0.
  - RUN: a press goes to PAUSE. If a press and a step boundary fall in the same cycle, the press wins and tick/step are frozen at their pre-edge values.
  - PAUSE: tick, step and led_n are frozen. A press returns to RUN, resuming from the frozen tick value.
  - DONE: the final pattern is held and done=1. A press restarts in RUN with step=0.
- Completion, modes 0-2: when step=N_LED-1 and tick=P-1, go to DONE. The total time in RUN is N_LED*P cycles.
- Mode 3 (BOUNCE) never reaches DONE. It runs until paused or reset.
- Patterns (bit i = LED i; "lit" means led_n[i]=0); led_n is decoded from registered state/step/mode only, with no path from inputs:
  - FILL: LEDs 0..step are lit.
  - CHASE: only LED[step] is lit.
  - COUNTDOWN: LEDs 0..N_LED-1-step are lit.
  - BOUNCE: only LED[pos] is lit. pos runs 0,1,...,N_LED-1,N_LED-2,...,1,0,1,...
    - A direction register flips at each end, so each end LED lights for exactly one period.
    - For N_LED=2, pos alternates 0,1,0,1.
- Output timing: led_n reflects the new step in the cycle after the boundary edge, i.e. one register stage, the same as step.
- busy and done are registered with the state.

Decomposition:
- Package led_seq_pkg holds:
  - mode encoding constants (FILL=0, CHASE=1, COUNTDOWN=2, BOUNCE=3)
  - state enum IDLE/RUN/PAUSE/DONE
  - a function computing the step width from N_LED
- Sub-module pb_sync_edge, parameter SYNC_STAGES, with ports o_clk, rst, pb_n, press. It performs synchronisation and falling-edge detection and is reusable by other button-driven blocks.

Test Plan:
1. Reset check: assert rst mid-RUN (FILL, step 2) -> same cycle led_n=4'b1111, busy=0, done=0. After release, with no press, the block stays in IDLE.
2. FILL, N_LED=4, dip=3, single press:
   - busy rises SYNC_STAGES+2 cycles after pb_n falls.
   - led_n sequence is 1110, 1100, 1000, 0000, each held 3 cycles.
   - done=1 after 12 RUN cycles; led_n stays 0000.
3. CHASE, dip=0 (treated as P=1):
   - led_n 1110, 1101, 1011, 0111 on consecutive cycles, then DONE.
   - Changing dip to 5 mid-run has no effect.
4. Pause/resume, COUNTDOWN, dip=4:
   - Press at step 1, tick 2 -> led_n 1000 frozen for 20 cycles.
   - Second press -> resumes, with 1 tick remaining before step 2 (led_n 1100).
   - Total RUN time remains 16 cycles.
5. BOUNCE, dip=2: lit index sequence 0,1,2,3,2,1,0,1,2 at 2 cycles each. done never asserts over 100 cycles.
6. Press held low for 50 cycles in IDLE -> exactly one start; no pause is triggered. A press in DONE restarts with step=0 and done=0.
